// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end for one shared pipelined unsigned
// multiplier. Each cycle it grants one requester and registers that
// requester's operands onto the multiplier inputs. A tag pipeline follows the
// products through the multiplier so each one goes back to its owner.
module mult_arbiter #(
  parameter int M    = 12,  // operand width, same as the multiplier's m
  parameter int NREQ = 4,   // number of requesters, 2..8
  parameter int LAT  = 1    // multiplier latency from a/b change to product
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*M-1:0]   req_a,
  input  logic [NREQ*M-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     res_valid,
  output logic [2*M-1:0]      res_data,
  output logic                busy,
  output logic [M-1:0]        mul_a,
  output logic [M-1:0]        mul_b,
  input  logic [2*M-1:0]      mul_p
);

  localparam int PW = $clog2(NREQ);

  // Round-robin pointer: the requester that has first priority this cycle.
  logic [PW-1:0]   ptr_q, ptr_d;

  // Arbitration result for the current cycle.
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            xfer;

  // Operands of the winning requester.
  logic [M-1:0]    sel_a, sel_b;
  logic [M-1:0]    mul_a_q, mul_a_d;
  logic [M-1:0]    mul_b_q, mul_b_d;

  // Tag pipeline. Stage 0 lines up with the registered operands, and stage
  // LAT lines up with the matching product on mul_p.
  logic [LAT:0]    tag_vld_q, tag_vld_d;
  logic [NREQ-1:0] tag_own_q [LAT+1];
  logic [NREQ-1:0] tag_own_d [LAT+1];

  logic [NREQ-1:0] res_valid_q, res_valid_d;
  logic [2*M-1:0]  res_data_q, res_data_d;

  // Scan the requests from the pointer upward, wrapping at NREQ. The first
  // active request wins.
  always_comb begin : arb
    logic [PW:0] cand;
    grant     = '0;
    grant_idx = '0;
    xfer      = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (!xfer && req_valid[cand[PW-1:0]]) begin
        xfer      = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
    if (xfer) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Select the winner's operands. On a grant, move the pointer to the
  // requester after the winner. With no grant, the pointer and operands hold.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*M +: M];
        sel_b = req_b[i*M +: M];
      end
    end
    mul_a_d = xfer ? sel_a : mul_a_q;
    mul_b_d = xfer ? sel_b : mul_b_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

  // Shift the tag pipeline every cycle. It never stalls, so stage 0 is
  // invalid on any cycle without a transfer.
  always_comb begin
    tag_vld_d[0] = xfer;
    tag_own_d[0] = grant;
    for (int s = 1; s <= LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_own_d[s] = tag_own_q[s-1];
    end
  end

  // Capture the product when the last tag stage is valid. Otherwise drop the
  // strobe and keep the previous data.
  always_comb begin
    res_valid_d = '0;
    res_data_d  = res_data_q;
    if (tag_vld_q[LAT]) begin
      res_valid_d = tag_own_q[LAT];
      res_data_d  = mul_p;
    end
  end

  // State registers. Reset discards every in-flight tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_vld_q   <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      for (int s = 0; s <= LAT; s++) begin
        tag_own_q[s] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_vld_q   <= tag_vld_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      for (int s = 0; s <= LAT; s++) begin
        tag_own_q[s] <= tag_own_d[s];
      end
    end
  end

  assign req_ready = grant;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = |tag_vld_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Testbench for mult_arbiter. A high-level model turns each grant into an
// expected product in a queue, and a separate monitor checks each result
// strobe against the head of that queue.
module tb_mult_arbiter;

  localparam int M    = 12;
  localparam int NREQ = 4;
  localparam int LAT  = 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*M-1:0]   req_a = '0;
  logic [NREQ*M-1:0]   req_b = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     res_valid;
  logic [2*M-1:0]      res_data;
  logic                busy;
  logic [M-1:0]        mul_a;
  logic [M-1:0]        mul_b;
  logic [2*M-1:0]      mul_p;

  mult_arbiter #(.M(M), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data),
    .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  always #5 clk = ~clk;

  // Registered multiplier with LAT cycles of latency.
  logic [2*M-1:0] mpipe [LAT];
  initial forever begin
    @(posedge clk);
    mpipe[0] <= {{M{1'b0}}, mul_a} * {{M{1'b0}}, mul_b};
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_p = mpipe[LAT-1];

  typedef struct {
    int             owner;
    logic [2*M-1:0] prod;
    int             issue;
  } exp_t;

  exp_t            exp_q[$];
  int              tests = 0;
  int              fails = 0;
  int              cyc = 0;

  // Reference model state.
  int              m_ptr = 0;
  logic [M-1:0]    m_a = '0;
  logic [M-1:0]    m_b = '0;
  logic [NREQ-1:0] model_grant = '0;

  // Requester drive state.
  logic [NREQ-1:0] v_drv = '0;
  logic [M-1:0]    a_drv [NREQ];
  logic [M-1:0]    b_drv [NREQ];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model. Round-robin from the pointer picks the winner, and each
  // winner adds its product to the scoreboard.
  int              g, idx;
  logic            bexp;
  logic [NREQ-1:0] oh;
  exp_t            e_new;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      model_grant = '0;
    end else begin
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
      bexp = 1'b0;
      foreach (exp_q[k]) begin
        if (cyc >= exp_q[k].issue + 1 && cyc <= exp_q[k].issue + LAT + 1) bexp = 1'b1;
      end
      chk("busy", busy, bexp);
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      oh = (g >= 0) ? (NREQ'(1) << g) : '0;
      chk("req_ready", req_ready, oh);
      if (g >= 0) begin
        m_a         = req_a[g*M +: M];
        m_b         = req_b[g*M +: M];
        e_new.owner = g;
        e_new.prod  = {{M{1'b0}}, m_a} * {{M{1'b0}}, m_b};
        e_new.issue = cyc;
        exp_q.push_back(e_new);
        m_ptr = (g + 1) % NREQ;
      end
      model_grant = oh;
    end
  end

  // Monitor. Each result strobe is checked against the oldest expected
  // product.
  exp_t e_got;
  initial forever begin
    @(negedge clk);
    if (res_valid !== '0) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL res_unexpected: got res_valid %b data %h, required no result (cycle %0d)",
                 res_valid, res_data, cyc);
      end else begin
        e_got = exp_q.pop_front();
        $display("[TB] result owner %0d data %h cycle %0d", e_got.owner, res_data, cyc);
        chk("res_valid", res_valid, NREQ'(1) << e_got.owner);
        chk("res_data", res_data, e_got.prod);
        chk("res_latency", cyc, e_got.issue + LAT + 2);
      end
    end else if (exp_q.size() > 0 && cyc >= exp_q[0].issue + LAT + 2) begin
      e_got = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL res_missing: got no strobe, required owner %0d data %h (cycle %0d)",
               e_got.owner, e_got.prod, cyc);
    end
  end

  task automatic apply_cycle();
    req_valid = v_drv;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*M +: M] = a_drv[i];
      req_b[i*M +: M] = b_drv[i];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    v_drv = '0;
    repeat (n) apply_cycle();
  endtask

  task automatic reset_dut();
    v_drv       = '0;
    req_valid   = '0;
    rst_n       = 1'b0;
    exp_q.delete();
    m_ptr       = 0;
    m_a         = '0;
    m_b         = '0;
    model_grant = '0;
    #1;
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [M-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return M'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      a_drv[i] = '0;
      b_drv[i] = '0;
    end
    #2;

    // One request from requester 0.
    reset_dut();
    a_drv[0] = 12'haaa; b_drv[0] = 12'haaa;
    v_drv = 4'b0001; apply_cycle();
    idle(5);

    // All requesters valid continuously.
    reset_dut();
    for (int i = 0; i < NREQ; i++) begin
      a_drv[i] = M'(i + 1);
      b_drv[i] = 12'hfff;
    end
    v_drv = 4'b1111;
    repeat (5) apply_cycle();
    idle(5);

    // A single requester held valid is granted back to back.
    reset_dut();
    a_drv[2] = 12'hfff; b_drv[2] = 12'hfff;
    v_drv = 4'b0100;
    repeat (5) apply_cycle();
    idle(5);

    // The pointer wraps from 3 back to 1 while requester 0 is idle.
    reset_dut();
    a_drv[1] = 12'h123; b_drv[1] = 12'h456;
    a_drv[3] = 12'h801; b_drv[3] = 12'h00f;
    v_drv = 4'b1000; apply_cycle();
    v_drv = 4'b1010; apply_cycle();
    v_drv = 4'b1010; apply_cycle();
    idle(5);

    // Reset with products still in flight.
    reset_dut();
    a_drv[0] = 12'h321; b_drv[0] = 12'h654;
    v_drv = 4'b0001;
    repeat (3) apply_cycle();
    idle(1);
    reset_dut();
    idle(4);
    v_drv = 4'b1111; apply_cycle();
    idle(5);

    // Requester 1 withdraws its request before it is granted.
    reset_dut();
    a_drv[0] = 12'h0ff; b_drv[0] = 12'h101;
    a_drv[1] = 12'hbad; b_drv[1] = 12'hcab;
    v_drv = 4'b0011; apply_cycle();
    v_drv = 4'b0001;
    repeat (4) apply_cycle();
    idle(5);

    // Random traffic with drops, re-requests and extreme operands.
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (v_drv[i] && model_grant[i]) begin
          if ($urandom_range(0, 9) < 7) begin
            a_drv[i] = rnd_op();
            b_drv[i] = rnd_op();
          end else begin
            v_drv[i] = 1'b0;
          end
        end else if (v_drv[i]) begin
          if ($urandom_range(0, 9) == 0) v_drv[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          v_drv[i] = 1'b1;
          a_drv[i] = rnd_op();
          b_drv[i] = rnd_op();
        end
      end
      apply_cycle();
    end
    idle(LAT + 4);
    chk("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
